// File: rtl/chan_scan_serializer_pkg.sv
// Shared types and derived-size helpers for the channel scan serializer.
// Sizes are functions so each module derives them from its own parameters.
package chan_scan_serializer_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic int sel_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beats_f(input int w, input int o);
    return (w + o - 1) / o;
  endfunction

  function automatic int beat_w_f(input int b);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

endpackage

// File: rtl/chan_scan_serializer_word_serializer.sv
// Snapshots one word and emits it LS beat first over valid/ready.
// o_done pulses on the edge that accepts the final beat.
module word_serializer
  import chan_scan_serializer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_done
);

  localparam int BEATS  = beats_f(WIDTH, OUT_W);
  localparam int BEAT_W = beat_w_f(BEATS);
  localparam int SW     = BEATS * OUT_W;

  logic [SW-1:0]     r_snap;
  logic [BEAT_W-1:0] r_beat;
  logic              r_valid;
  logic              r_last;
  logic [SW-1:0]     w_ext;
  logic [SW-1:0]     w_shift;
  logic              w_acc;

  assign w_acc  = r_valid & i_ready;
  assign o_done = w_acc & r_last;

  always_comb begin
    w_ext = '0;
    w_ext[WIDTH-1:0] = i_word;
  end

  // Current beat always sits in the low OUT_W bits of the snapshot.
  assign w_shift = r_snap >> OUT_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap  <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_snap  <= w_ext;
      r_beat  <= '0;
      r_valid <= 1'b1;
      r_last  <= (BEATS == 1);
    end else if (w_acc) begin
      if (r_last) begin
        r_snap  <= '0;
        r_beat  <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_snap <= w_shift;
        r_beat <= r_beat + 1'b1;
        r_last <= (int'(r_beat) == BEATS - 2);
      end
    end
  end

  assign o_data  = r_snap[OUT_W-1:0];
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/chan_scan_serializer.sv
// Picks a channel word by host select or round-robin scan and
// streams it out as narrow beats; back-to-back words in scan mode.
module chan_scan_serializer
  import chan_scan_serializer_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*WIDTH-1:0]     data_in,
  input  logic [sel_w_f(N)-1:0]  sel,
  input  logic                   req,
  input  logic                   auto_en,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [sel_w_f(N)-1:0]  out_chan,
  output logic                   busy
);

  localparam int SEL_W = sel_w_f(N);

  state_t           r_state;
  logic [SEL_W-1:0] r_scan;
  logic [SEL_W-1:0] r_chan;
  logic             r_busy;
  logic             r_auto_src;

  logic [SEL_W-1:0] w_nxt_scan;
  logic [SEL_W-1:0] w_sel;
  logic [SEL_W-1:0] w_ch;
  logic [WIDTH-1:0] w_word;
  logic             w_start;
  logic             w_src_auto;
  logic             w_done;

  always_comb begin
    w_nxt_scan = (int'(r_scan) == N - 1) ? '0 : r_scan + 1'b1;
    w_sel      = (int'(sel) < N) ? sel : '0;
    w_start    = 1'b0;
    w_ch       = r_scan;
    w_src_auto = 1'b1;
    unique case (1'b1)
      (r_state == IDLE) && auto_en: begin
        w_start = 1'b1;
      end
      (r_state == IDLE) && !auto_en && req: begin
        w_start    = 1'b1;
        w_ch       = w_sel;
        w_src_auto = 1'b0;
      end
      // Chain the next scan word on the same edge as the last beat.
      (r_state == SEND) && w_done && auto_en: begin
        w_start = 1'b1;
        w_ch    = r_auto_src ? w_nxt_scan : r_scan;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_word = '0;
    for (int k = 0; k < N; k++) begin
      if (w_ch == SEL_W'(k)) w_word = data_in[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_scan     <= '0;
      r_chan     <= '0;
      r_busy     <= 1'b0;
      r_auto_src <= 1'b0;
    end else begin
      if (w_start) begin
        r_chan     <= w_ch;
        r_auto_src <= w_src_auto;
      end
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= SEND;
            r_busy  <= 1'b1;
          end
        end
        SEND: begin
          if (w_done) begin
            if (r_auto_src) r_scan <= w_nxt_scan;
            if (!auto_en) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  word_serializer #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_start),
    .i_word  (w_word),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_valid (out_valid),
    .o_last  (out_last),
    .o_done  (w_done)
  );

  assign out_chan = r_chan;
  assign busy     = r_busy;

endmodule

// File: tb/tb_chan_scan_serializer.sv
// Directed bench for chan_scan_serializer (N=4, WIDTH=16, OUT_W=8).
module tb_chan_scan_serializer;

  logic        clk;
  logic        rst_n;
  logic [15:0] ch [4];
  logic [63:0] data_in;
  logic [1:0]  sel;
  logic        req;
  logic        auto_en;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_chan;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_d [11] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A,
                             8'hF0, 8'hDE, 8'h34, 8'h12, 8'h78};
  logic [1:0] exp_c [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                             2'd3, 2'd3, 2'd0, 2'd0, 2'd1};

  assign data_in = {ch[3], ch[2], ch[1], ch[0]};

  chan_scan_serializer #(
    .N     (4),
    .WIDTH (16),
    .OUT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .sel       (sel),
    .req       (req),
    .auto_en   (auto_en),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_chan  (out_chan),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [7:0] d,
                      input logic l, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".last"}, 32'(out_last), 32'(l));
    chk({tag, ".chan"}, 32'(out_chan), 32'(c));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic idle(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".data"}, 32'(out_data), 32'd0);
    chk({tag, ".last"}, 32'(out_last), 32'd0);
    chk({tag, ".chan"}, 32'(out_chan), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    auto_en   = 1'b0;
    req       = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    ch[0] = 16'h1234;
    ch[1] = 16'h5678;
    ch[2] = 16'h9ABC;
    ch[3] = 16'hDEF0;
    #3;
    rst_vals("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    idle("post_reset");

    // Manual transfer of ch2
    sel = 2'd2;
    req = 1'b1;
    tick();
    req = 1'b0;
    beat("man_b0", 8'hBC, 1'b0, 2'd2);
    tick();
    beat("man_b1", 8'h9A, 1'b1, 2'd2);
    tick();
    idle("man_end");

    // Backpressure on ch1
    sel = 2'd1;
    req = 1'b1;
    tick();
    req = 1'b0;
    out_ready = 1'b0;
    beat("bp_hold0", 8'h78, 1'b0, 2'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("bp_hold", 8'h78, 1'b0, 2'd1);
    end
    out_ready = 1'b1;
    tick();
    beat("bp_b1", 8'h56, 1'b1, 2'd1);
    tick();
    idle("bp_end");

    // Snapshot isolation and req while busy
    sel = 2'd0;
    req = 1'b1;
    tick();
    req = 1'b0;
    ch[0] = 16'hFFFF;
    beat("snap_b0", 8'h34, 1'b0, 2'd0);
    sel = 2'd3;
    req = 1'b1;
    tick();
    req = 1'b0;
    beat("snap_b1", 8'h12, 1'b1, 2'd0);
    tick();
    idle("snap_end");
    tick();
    idle("snap_nodup");
    ch[0] = 16'h1234;

    // Auto scan from ch0, gapless, then drop mode during ch1 beat 0
    auto_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      beat("scan", exp_d[i], 1'(i % 2), exp_c[i]);
    end
    auto_en = 1'b0;
    tick();
    beat("drop_b1", 8'h56, 1'b1, 2'd1);
    tick();
    idle("drop_end");

    // Manual word must not move the scan pointer
    sel = 2'd3;
    req = 1'b1;
    tick();
    req = 1'b0;
    beat("man3_b0", 8'hF0, 1'b0, 2'd3);
    tick();
    beat("man3_b1", 8'hDE, 1'b1, 2'd3);
    tick();
    idle("man3_end");

    // Resume scan at ch2
    auto_en = 1'b1;
    tick();
    beat("resume_b0", 8'hBC, 1'b0, 2'd2);
    tick();
    beat("resume_b1", 8'h9A, 1'b1, 2'd2);
    tick();
    beat("resume_ch3", 8'hF0, 1'b0, 2'd3);

    // Asynchronous reset mid-word
    rst_n = 1'b0;
    #1;
    rst_vals("async_rst");
    tick();
    tick();
    rst_vals("rst_hold");
    rst_n = 1'b1;
    tick();
    beat("restart_b0", 8'h34, 1'b0, 2'd0);
    tick();
    beat("restart_b1", 8'h12, 1'b1, 2'd0);
    tick();
    beat("restart_ch1", 8'h78, 1'b0, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
